// File: rtl/tilemap_mixer_n_if.sv
// Pixel-side bus of the N-layer tilemap mixer: tile/attribute loads, CPU priority
// writes, the daisy-chained upstream pixel and the mixed result.
interface tilemap_mixer_n_if #(
  parameter int NUM_LAYERS = 2,
  parameter int BPP        = 3,
  parameter int PIX        = 8,
  parameter int ATTR_W     = 8,
  parameter int PRI_W      = 3,
  parameter int CA_W       = 3
);
  logic                          CE;
  logic                          FLIP;
  logic [NUM_LAYERS-1:0]         LOAD;
  logic [NUM_LAYERS*ATTR_W-1:0]  ATTR;
  logic [NUM_LAYERS*BPP*PIX-1:0] GD;
  logic                          nWE;
  logic [CA_W-1:0]               CA;
  logic [PRI_W-1:0]              MDI;
  logic [PRI_W-1:0]              PRI;
  logic [ATTR_W-1:0]             CLI;
  logic [BPP-1:0]                DTI;
  logic [PRI_W-1:0]              PRO;
  logic [ATTR_W-1:0]             CLO;
  logic [BPP-1:0]                DTO;
  logic                          CLE;

  modport master (output CE, FLIP, LOAD, ATTR, GD, nWE, CA, MDI, PRI, CLI, DTI,
                  input  PRO, CLO, DTO, CLE);
  modport slave  (input  CE, FLIP, LOAD, ATTR, GD, nWE, CA, MDI, PRI, CLI, DTI,
                  output PRO, CLO, DTO, CLE);
endinterface

// File: rtl/tilemap_mixer_n.sv
// N-layer tilemap pixel serialiser and priority mixer. Each layer shifts out one
// pixel per CE; the highest-priority opaque layer competes with the upstream pixel.
module tilemap_mixer_n_layer #(
  parameter int BPP    = 3,
  parameter int PIX    = 8,
  parameter int ATTR_W = 8,
  parameter int PRI_W  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 flip,
  input  logic                 load,
  input  logic [ATTR_W-1:0]    attr_in,
  input  logic [BPP*PIX-1:0]   gd,
  input  logic                 pwr,
  input  logic [PRI_W-1:0]     mdi,
  output logic [BPP-1:0]       dt,
  output logic [ATTR_W-1:0]    attr,
  output logic [PRI_W-1:0]     prio
);
  localparam int CW = $clog2(PIX + 1);

  logic [BPP-1:0][PIX-1:0] sh_q, sh_d;
  logic [ATTR_W-1:0]       attr_q, attr_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PRI_W-1:0]        prio_q, prio_d;
  logic [PIX-1:0]          row;

  always_comb begin
    sh_d   = sh_q;
    attr_d = attr_q;
    cnt_d  = cnt_q;
    row    = '0;
    prio_d = pwr ? mdi : prio_q;
    if (ce) begin
      if (load) begin
        sh_d   = gd;
        attr_d = attr_in;
        cnt_d  = CW'(PIX);
      end else if (cnt_q != '0) begin
        // shift toward the head selected by the current FLIP; vacated bits read transparent
        for (int p = 0; p < BPP; p++) begin
          if (flip) begin
            row          = sh_q[p] >> 1;
            row[PIX-1]   = 1'b1;
          end else begin
            row          = sh_q[p] << 1;
            row[0]       = 1'b1;
          end
          sh_d[p] = row;
        end
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_comb begin
    dt = '1;
    if (cnt_q != '0)
      for (int p = 0; p < BPP; p++)
        dt[p] = flip ? sh_q[p][0] : sh_q[p][PIX-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q   <= '1;
      attr_q <= '0;
      cnt_q  <= '0;
      prio_q <= '0;
    end else begin
      sh_q   <= sh_d;
      attr_q <= attr_d;
      cnt_q  <= cnt_d;
      prio_q <= prio_d;
    end
  end

  assign attr = attr_q;
  assign prio = prio_q;
endmodule

module tilemap_mixer_n #(
  parameter int NUM_LAYERS = 2,
  parameter int BPP        = 3,
  parameter int PIX        = 8,
  parameter int ATTR_W     = 8,
  parameter int PRI_W      = 3,
  parameter int CA_W       = 3
) (
  input  logic             CLK_6M,
  input  logic             nRESET,
  tilemap_mixer_n_if.slave bus
);
  logic [NUM_LAYERS-1:0][BPP-1:0]    ly_dt;
  logic [NUM_LAYERS-1:0][ATTR_W-1:0] ly_attr;
  logic [NUM_LAYERS-1:0][PRI_W-1:0]  ly_prio;

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    tilemap_mixer_n_layer #(.BPP(BPP), .PIX(PIX), .ATTR_W(ATTR_W), .PRI_W(PRI_W)) u_layer (
      .clk     (CLK_6M),
      .rst_n   (nRESET),
      .ce      (bus.CE),
      .flip    (bus.FLIP),
      .load    (bus.LOAD[i]),
      .attr_in (bus.ATTR[i*ATTR_W +: ATTR_W]),
      .gd      (bus.GD[i*BPP*PIX +: BPP*PIX]),
      .pwr     (!bus.nWE && (bus.CA == CA_W'(i))),
      .mdi     (bus.MDI),
      .dt      (ly_dt[i]),
      .attr    (ly_attr[i]),
      .prio    (ly_prio[i])
    );
  end

  logic              win_vld, take;
  logic [PRI_W-1:0]  win_pri;
  logic [ATTR_W-1:0] win_attr;
  logic [BPP-1:0]    win_dt;
  logic [PRI_W-1:0]  pro_q, pro_d;
  logic [ATTR_W-1:0] clo_q, clo_d;
  logic [BPP-1:0]    dto_q, dto_d;
  logic              cle_q, cle_d;

  always_comb begin
    win_vld  = 1'b0;
    win_pri  = '0;
    win_attr = '0;
    win_dt   = '1;
    // strict '>' keeps the lowest index on priority ties
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (ly_dt[i] != '1 && (!win_vld || ly_prio[i] > win_pri)) begin
        win_vld  = 1'b1;
        win_pri  = ly_prio[i];
        win_attr = ly_attr[i];
        win_dt   = ly_dt[i];
      end
    end
    take = win_vld && (bus.DTI == '1 || win_pri > bus.PRI);
  end

  always_comb begin
    pro_d = pro_q;
    clo_d = clo_q;
    dto_d = dto_q;
    cle_d = cle_q;
    if (bus.CE) begin
      if (take) begin
        pro_d = win_pri;
        clo_d = win_attr;
        dto_d = win_dt;
        cle_d = 1'b1;
      end else begin
        pro_d = bus.PRI;
        clo_d = bus.CLI;
        dto_d = bus.DTI;
        cle_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_6M or negedge nRESET) begin
    if (!nRESET) begin
      pro_q <= '0;
      clo_q <= '0;
      dto_q <= '1;
      cle_q <= 1'b0;
    end else begin
      pro_q <= pro_d;
      clo_q <= clo_d;
      dto_q <= dto_d;
      cle_q <= cle_d;
    end
  end

  assign bus.PRO = pro_q;
  assign bus.CLO = clo_q;
  assign bus.DTO = dto_q;
  assign bus.CLE = cle_q;
endmodule

// File: tb/tb_tilemap_mixer_n.sv
// Directed bench for tilemap_mixer_n: a vector table for serialise/flip/priority/
// transparency, then hand sequences for async reset and back-to-back row reloads.
module tb_tilemap_mixer_n;
  localparam int NL = 2, BPP = 3, PIX = 8, AW = 8, PW = 3, CAW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tilemap_mixer_n_if #(.NUM_LAYERS(NL), .BPP(BPP), .PIX(PIX), .ATTR_W(AW), .PRI_W(PW), .CA_W(CAW)) bus ();

  tilemap_mixer_n #(.NUM_LAYERS(NL), .BPP(BPP), .PIX(PIX), .ATTR_W(AW), .PRI_W(PW), .CA_W(CAW)) dut (
    .CLK_6M (clk),
    .nRESET (rst_n),
    .bus    (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        ce;
    logic        flip;
    logic [1:0]  load;
    logic [15:0] attr;
    logic [47:0] gd;
    logic        nwe;
    logic [2:0]  ca;
    logic [2:0]  mdi;
    logic [2:0]  pri;
    logic [7:0]  cli;
    logic [2:0]  dti;
    logic [2:0]  pro;
    logic [7:0]  clo;
    logic [2:0]  dto;
    logic        cle;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int ce, input int flip, input int load, input int attr,
                              input logic [47:0] gd, input int nwe, input int ca, input int mdi,
                              input int pri, input int cli, input int dti,
                              input int pro, input int clo, input int dto, input int cle);
    vec_t v;
    v.ce = 1'(ce);   v.flip = 1'(flip); v.load = 2'(load); v.attr = 16'(attr);
    v.gd = gd;       v.nwe = 1'(nwe);   v.ca = 3'(ca);     v.mdi = 3'(mdi);
    v.pri = 3'(pri); v.cli = 8'(cli);   v.dti = 3'(dti);
    v.pro = 3'(pro); v.clo = 8'(clo);   v.dto = 3'(dto);   v.cle = 1'(cle);
    return v;
  endfunction

  // layer 0 planes 0..2, then layer 1 planes 0..2
  function automatic logic [47:0] gd2(input logic [7:0] a0, input logic [7:0] a1, input logic [7:0] a2,
                                      input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    return {b2, b1, b0, a2, a1, a0};
  endfunction

  task automatic chk(input string nm, input logic [2:0] pro, input logic [7:0] clo,
                     input logic [2:0] dto, input logic cle);
    n_tests++;
    if ({bus.PRO, bus.CLO, bus.DTO, bus.CLE} !== {pro, clo, dto, cle}) begin
      n_fail++;
      $display("FAIL %s: got PRO=%0d CLO=%h DTO=%0d CLE=%0d, want PRO=%0d CLO=%h DTO=%0d CLE=%0d",
               nm, bus.PRO, bus.CLO, bus.DTO, bus.CLE, pro, clo, dto, cle);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    bus.CE = v.ce;   bus.FLIP = v.flip; bus.LOAD = v.load; bus.ATTR = v.attr;
    bus.GD = v.gd;   bus.nWE = v.nwe;   bus.CA = v.ca;     bus.MDI = v.mdi;
    bus.PRI = v.pri; bus.CLI = v.cli;   bus.DTI = v.dti;
    @(posedge clk);
    #1;
    chk(nm, v.pro, v.clo, v.dto, v.cle);
  endtask

  initial begin
    logic [47:0] g1, g2, g3, z;
    int pa[8];
    int pb[8];
    logic [7:0] rows[2];
    logic [7:0] rattr[2];
    logic [2:0] epro, edto;
    logic [7:0] eclo;
    logic       ecle;

    g1 = gd2(8'hF0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    g2 = gd2(8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF);
    g3 = gd2(8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
    z  = '0;
    pa = '{1, 1, 1, 1, 0, 0, 0, 0};
    pb = '{0, 0, 0, 0, 1, 1, 1, 1};

    // serialise, MSB first, L0 prio 1
    vq.push_back(mk(0,0,0,0,z,      0,0,1, 0,0,7, 0,0,7,0));
    vq.push_back(mk(1,0,1,16'h003C,g1, 1,0,0, 0,0,7, 0,0,7,0));
    for (int k = 0; k < 8; k++) vq.push_back(mk(1,0,0,0,z, 1,0,0, 0,0,7, 1,8'h3C,pa[k],1));
    vq.push_back(mk(1,0,0,0,z,      1,0,0, 0,0,7, 0,0,7,0));
    // flip
    vq.push_back(mk(1,1,1,16'h003C,g1, 1,0,0, 0,0,7, 0,0,7,0));
    for (int k = 0; k < 8; k++) vq.push_back(mk(1,1,0,0,z, 1,0,0, 0,0,7, 1,8'h3C,pb[k],1));
    vq.push_back(mk(1,1,0,0,z,      1,0,0, 0,0,7, 0,0,7,0));
    // priority: L0 prio 2 DT 3, L1 prio 5 DT 4
    vq.push_back(mk(0,0,0,0,z,      0,0,2, 0,0,7, 0,0,7,0));
    vq.push_back(mk(0,0,0,0,z,      0,1,5, 0,0,7, 0,0,7,0));
    vq.push_back(mk(1,0,3,16'h2211,g2, 1,0,0, 0,0,7, 0,0,7,0));
    vq.push_back(mk(1,0,0,0,z,      1,0,0, 0,0,7, 5,8'h22,4,1));
    vq.push_back(mk(1,0,0,0,z,      0,0,5, 0,0,7, 5,8'h22,4,1));
    vq.push_back(mk(1,0,0,0,z,      1,0,0, 0,0,7, 5,8'h11,3,1));
    vq.push_back(mk(1,0,0,0,z,      1,0,0, 5,8'hAA,2, 5,8'hAA,2,0));
    vq.push_back(mk(1,0,0,0,z,      1,0,0, 4,8'hAA,2, 5,8'h11,3,1));
    // transparency: L1 all-ones, L0 DT 6 prio 1; out-of-range CA write ignored
    vq.push_back(mk(1,0,3,16'h6655,g3, 0,0,1, 0,0,7, 5,8'h11,3,1));
    vq.push_back(mk(1,0,0,0,z,      0,5,7, 0,0,7, 1,8'h55,6,1));
    vq.push_back(mk(1,0,0,0,z,      1,0,0, 0,0,7, 1,8'h55,6,1));
    vq.push_back(mk(1,0,0,0,z,      1,0,0, 7,8'hBB,7, 1,8'h55,6,1));

    bus.CE = 1'b0; bus.FLIP = 1'b0; bus.LOAD = '0; bus.ATTR = '0; bus.GD = '0;
    bus.nWE = 1'b1; bus.CA = '0; bus.MDI = '0; bus.PRI = '0; bus.CLI = '0; bus.DTI = 3'd7;
    #12;
    chk("reset_init", 3'd0, 8'h00, 3'd7, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("vec%0d", i));

    // async reset mid-row
    #3 rst_n = 1'b0;
    #1 chk("reset_async", 3'd0, 8'h00, 3'd7, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step(mk(1,0,0,0,z, 1,0,0, 0,0,7, 0,0,7,0), $sformatf("post_reset%0d", i));
    // reset priority is 0: a local layer does not beat PRI=0 unless DTI is transparent
    step(mk(1,0,1,16'h0077,z, 1,0,0, 0,0,7, 0,0,7,0), "prio_rst_load");
    step(mk(1,0,0,0,z, 1,0,0, 0,8'hCC,2, 0,8'hCC,2,0), "prio_rst_up");
    step(mk(1,0,0,0,z, 1,0,0, 0,0,7, 0,8'h77,0,1), "prio_rst_local");

    // back-to-back rows with CE toggling; L0 prio 1
    step(mk(0,0,0,0,z, 0,0,1, 0,0,7, 0,8'h77,0,1), "b2b_hold_wr");
    rows[0] = 8'hA5; rows[1] = 8'h3C; rattr[0] = 8'h41; rattr[1] = 8'h42;
    step(mk(1,0,1,{8'h00, rattr[0]},gd2(rows[0],8'h00,8'h00,8'h00,8'h00,8'h00), 1,0,0, 0,0,7, 1,8'h77,0,1), "b2b_load0");
    epro = 3'd1; eclo = 8'h77; edto = 3'd0; ecle = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      int r, k;
      r = (e - 1) / 8;
      k = (e - 1) % 8;
      step(mk(0,0,1,0,z, 1,0,0, 0,0,7, epro,eclo,edto,ecle), $sformatf("b2b_hold%0d", e));
      epro = 3'd1; eclo = rattr[r]; edto = {2'b00, rows[r][7-k]}; ecle = 1'b1;
      if (e == 8)
        step(mk(1,0,1,{8'h00, rattr[1]},gd2(rows[1],8'h00,8'h00,8'h00,8'h00,8'h00), 1,0,0, 0,0,7,
                epro,eclo,edto,ecle), $sformatf("b2b_px%0d", e));
      else
        step(mk(1,0,0,0,z, 1,0,0, 0,0,7, epro,eclo,edto,ecle), $sformatf("b2b_px%0d", e));
    end
    step(mk(1,0,0,0,z, 1,0,0, 0,0,7, 0,0,7,0), "b2b_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
